// File: rtl/sobel_pkg.sv
// sobel_pkg: shared encodings and defaults for the Sobel streaming engine.
//   - mode_e  : operating modes as driven on i_mode
//   - state_e : engine FSM states (also exported on the debug state output)
//   - default pixel / address widths and the default line-buffer depth
package sobel_pkg;

    localparam int SOBEL_DATA_WIDTH = 8;
    localparam int SOBEL_ADDR_WIDTH = 16;
    localparam int SOBEL_MAX_WIDTH  = 256;

    typedef enum logic [1:0] {
        MODE_MOVE   = 2'd0,
        MODE_SOBEL  = 2'd1,
        MODE_THRESH = 2'd2,
        MODE_RSVD   = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Both gradient modes need a full 3x3 neighbourhood.
    function automatic logic is_sobel_mode(input logic [1:0] mode);
        return (mode == MODE_SOBEL) || (mode == MODE_THRESH);
    endfunction

endpackage

// File: rtl/sobel_line_buffer.sv
// sobel_line_buffer: two image rows of history, MAX_WIDTH pixels deep.
//   clk     : clock
//   push_i  : a new pixel for column col_i is accepted this cycle
//   col_i   : column of the incoming pixel
//   pix_i   : incoming pixel (current row)
//   row1_o  : pixel at col_i from the previous row
//   row2_o  : pixel at col_i from two rows back
// Reads are combinational and return the contents before this cycle's push,
// so the caller sees the column {row2, row1, pix} in the same cycle.
// Contents are not reset: the engine never uses rows it has not yet written
// in the current frame.
module sobel_line_buffer
    import sobel_pkg::*;
#(
    parameter int DATA_WIDTH = SOBEL_DATA_WIDTH,
    parameter int MAX_WIDTH  = SOBEL_MAX_WIDTH,
    parameter int COL_W      = $clog2(MAX_WIDTH)
) (
    input  logic                  clk,
    input  logic                  push_i,
    input  logic [COL_W-1:0]      col_i,
    input  logic [DATA_WIDTH-1:0] pix_i,
    output logic [DATA_WIDTH-1:0] row1_o,
    output logic [DATA_WIDTH-1:0] row2_o
);

    logic [DATA_WIDTH-1:0] row1_mem [MAX_WIDTH];
    logic [DATA_WIDTH-1:0] row2_mem [MAX_WIDTH];

    assign row1_o = row1_mem[col_i];
    assign row2_o = row2_mem[col_i];

    // Each column slot ages by one row per push at that column.
    always_ff @(posedge clk) begin
        if (push_i) begin
            row1_mem[col_i] <= pix_i;
            row2_mem[col_i] <= row1_mem[col_i];
        end
    end

endmodule

// File: rtl/sobel_stream_engine.sv
// sobel_stream_engine: streams a W x H image from a source BRAM (b0) once in
// raster order and writes either a copy (MOVE), the Sobel magnitude (SOBEL)
// or a binarised magnitude (SOBEL_THRESH) to a destination BRAM (b1).
//   clk, rst_n            : clock, asynchronous active-low reset
//   i_start / i_abort     : frame start pulse (IDLE only) / synchronous abort
//   i_mode, i_width,
//   i_height, i_thresh    : frame configuration, captured on i_start
//   b0_ce1/b0_addr1/b0_q1 : source read port
//   b1_ce1/b1_we1/
//   b1_addr1/b1_d1        : destination write port
//   o_idle/o_busy/
//   o_done/o_err          : status; o_done and o_err are one-cycle pulses
//   o_dbg_state           : current FSM state (state_e encoding)
// Interface timing: b0 is a strobe-only read port, b0_q1 holds the pixel
// addressed by b0_addr1 exactly one cycle after b0_ce1; b1 is a strobe-only
// write port with no back-pressure, a write happens in every cycle b1_we1 is 1.
// Pipeline: issue (cycle t) -> pixel into window (t+1) -> gradient and output
// register (t+2) -> b1 write visible (t+3).
module sobel_stream_engine
    import sobel_pkg::*;
#(
    parameter int DATA_WIDTH = SOBEL_DATA_WIDTH,
    parameter int ADDR_WIDTH = SOBEL_ADDR_WIDTH,
    parameter int MAX_WIDTH  = SOBEL_MAX_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_start,
    input  logic                  i_abort,
    input  logic [1:0]            i_mode,
    input  logic [ADDR_WIDTH-1:0] i_width,
    input  logic [ADDR_WIDTH-1:0] i_height,
    input  logic [DATA_WIDTH-1:0] i_thresh,
    output logic                  b0_ce1,
    output logic [ADDR_WIDTH-1:0] b0_addr1,
    input  logic [DATA_WIDTH-1:0] b0_q1,
    output logic                  b1_ce1,
    output logic                  b1_we1,
    output logic [ADDR_WIDTH-1:0] b1_addr1,
    output logic [DATA_WIDTH-1:0] b1_d1,
    output logic                  o_idle,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_err,
    output logic [1:0]            o_dbg_state
);

    localparam int COL_W = $clog2(MAX_WIDTH);
    localparam int GW    = DATA_WIDTH + 4;

    state_e                state_q, state_d;
    mode_e                 mode_q;
    logic [ADDR_WIDTH-1:0] width_q, height_q;
    logic [DATA_WIDTH-1:0] thresh_q;
    logic                  err_q;

    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_col_q, rd_row_q;
    logic                  s1_v_q;
    logic [ADDR_WIDTH-1:0] s1_col_q, s1_row_q;
    logic                  s2_v_q, s2_wr_q;
    logic                  b1_we_q;
    logic [ADDR_WIDTH-1:0] b1_addr_q, wr_cnt_q;
    logic [DATA_WIDTH-1:0] b1_d_q;

    logic                  cfg_ok, start_go, last_issue;
    logic [DATA_WIDTH-1:0] lb_row1, lb_row2;
    logic [DATA_WIDTH-1:0] win_q [3][3];
    logic signed [GW-1:0]  gx, gy;
    logic [GW-1:0]         abs_gx, abs_gy, mag;
    logic [DATA_WIDTH-1:0] mag_sat, out_pix;

    // ---------------------------------------------------------------- config
    always_comb begin
        cfg_ok = 1'b1;
        if (i_mode == MODE_RSVD)                       cfg_ok = 1'b0;
        if (i_width == '0 || i_height == '0)           cfg_ok = 1'b0;
        if (32'(i_width) > MAX_WIDTH)                  cfg_ok = 1'b0;
        if (is_sobel_mode(i_mode) &&
            (32'(i_width) < 3 || 32'(i_height) < 3))   cfg_ok = 1'b0;
    end

    assign start_go   = (state_q == ST_IDLE) && i_start && !i_abort;
    assign last_issue = (rd_col_q == width_q - 1'b1) && (rd_row_q == height_q - 1'b1);

    // ------------------------------------------------------------------- FSM
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start_go) state_d = cfg_ok ? ST_READ : ST_DONE;
            ST_READ:  if (last_issue) state_d = ST_DRAIN;
            // Once both pipeline stages are empty the final write is on b1.
            ST_DRAIN: if (!s1_v_q && !s2_v_q) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        if (i_abort) state_d = ST_IDLE;
    end

    // ------------------------------------------------ counters and pipeline
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            mode_q    <= MODE_MOVE;
            width_q   <= '0;
            height_q  <= '0;
            thresh_q  <= '0;
            err_q     <= 1'b0;
            rd_addr_q <= '0;
            rd_col_q  <= '0;
            rd_row_q  <= '0;
            s1_v_q    <= 1'b0;
            s1_col_q  <= '0;
            s1_row_q  <= '0;
            s2_v_q    <= 1'b0;
            s2_wr_q   <= 1'b0;
            b1_we_q   <= 1'b0;
            b1_addr_q <= '0;
            b1_d_q    <= '0;
            wr_cnt_q  <= '0;
        end else begin
            state_q <= state_d;
            if (i_abort) begin
                // Flushing every in-flight stage silences b1 from the next cycle.
                err_q   <= 1'b0;
                s1_v_q  <= 1'b0;
                s2_v_q  <= 1'b0;
                s2_wr_q <= 1'b0;
                b1_we_q <= 1'b0;
            end else begin
                if (start_go) begin
                    mode_q    <= mode_e'(i_mode);
                    width_q   <= i_width;
                    height_q  <= i_height;
                    thresh_q  <= i_thresh;
                    err_q     <= !cfg_ok;
                    rd_addr_q <= '0;
                    rd_col_q  <= '0;
                    rd_row_q  <= '0;
                    wr_cnt_q  <= '0;
                end
                if (state_q == ST_READ && !last_issue) begin
                    rd_addr_q <= rd_addr_q + 1'b1;
                    if (rd_col_q == width_q - 1'b1) begin
                        rd_col_q <= '0;
                        rd_row_q <= rd_row_q + 1'b1;
                    end else begin
                        rd_col_q <= rd_col_q + 1'b1;
                    end
                end
                s1_v_q   <= (state_q == ST_READ);
                s1_col_q <= rd_col_q;
                s1_row_q <= rd_row_q;
                s2_v_q   <= s1_v_q;
                // The window is complete only once two columns and two rows
                // of this frame precede the newest pixel; this also discards
                // the two columns straddling a row wrap.
                s2_wr_q  <= s1_v_q && ((mode_q == MODE_MOVE) ||
                            (s1_col_q >= ADDR_WIDTH'(2) && s1_row_q >= ADDR_WIDTH'(2)));
                b1_we_q  <= s2_wr_q;
                if (s2_wr_q) begin
                    b1_addr_q <= wr_cnt_q;
                    b1_d_q    <= out_pix;
                    wr_cnt_q  <= wr_cnt_q + 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------ neighbourhood
    sobel_line_buffer #(
        .DATA_WIDTH (DATA_WIDTH),
        .MAX_WIDTH  (MAX_WIDTH),
        .COL_W      (COL_W)
    ) u_line_buffer (
        .clk    (clk),
        .push_i (s1_v_q),
        .col_i  (s1_col_q[COL_W-1:0]),
        .pix_i  (b0_q1),
        .row1_o (lb_row1),
        .row2_o (lb_row2)
    );

    // win_q[row][col]: row 0 is oldest (top), col 2 is newest (right).
    always_ff @(posedge clk) begin
        if (s1_v_q) begin
            for (int r = 0; r < 3; r++) begin
                win_q[r][0] <= win_q[r][1];
                win_q[r][1] <= win_q[r][2];
            end
            win_q[0][2] <= lb_row2;
            win_q[1][2] <= lb_row1;
            win_q[2][2] <= b0_q1;
        end
    end

    // ------------------------------------------------------------ gradient
    function automatic logic signed [GW-1:0] ext(input logic [DATA_WIDTH-1:0] p);
        return signed'({{(GW-DATA_WIDTH){1'b0}}, p});
    endfunction

    assign gx = (ext(win_q[0][2]) + (ext(win_q[1][2]) <<< 1) + ext(win_q[2][2]))
              - (ext(win_q[0][0]) + (ext(win_q[1][0]) <<< 1) + ext(win_q[2][0]));
    assign gy = (ext(win_q[2][0]) + (ext(win_q[2][1]) <<< 1) + ext(win_q[2][2]))
              - (ext(win_q[0][0]) + (ext(win_q[0][1]) <<< 1) + ext(win_q[0][2]));

    // Each |G| is below 2^(DATA_WIDTH+2), so the sum cannot overflow GW bits.
    assign abs_gx  = gx[GW-1] ? GW'(-gx) : GW'(gx);
    assign abs_gy  = gy[GW-1] ? GW'(-gy) : GW'(gy);
    assign mag     = abs_gx + abs_gy;
    assign mag_sat = (|mag[GW-1:DATA_WIDTH]) ? '1 : mag[DATA_WIDTH-1:0];

    always_comb begin
        out_pix = mag_sat;
        case (mode_q)
            MODE_MOVE:   out_pix = win_q[2][2];
            MODE_THRESH: out_pix = (mag_sat >= thresh_q) ? '1 : '0;
            default:     out_pix = mag_sat;
        endcase
    end

    // --------------------------------------------------------------- outputs
    assign b0_ce1      = (state_q == ST_READ);
    assign b0_addr1    = rd_addr_q;
    assign b1_we1      = b1_we_q;
    assign b1_ce1      = b1_we_q;
    assign b1_addr1    = b1_addr_q;
    assign b1_d1       = b1_d_q;
    assign o_idle      = (state_q == ST_IDLE);
    assign o_busy      = (state_q == ST_READ) || (state_q == ST_DRAIN);
    assign o_done      = (state_q == ST_DONE);
    assign o_err       = (state_q == ST_DONE) && err_q;
    assign o_dbg_state = state_q;

endmodule

// File: tb/tb_sobel_stream_engine.sv
// Directed testbench for sobel_stream_engine: behavioural source BRAM, a
// scoreboard queue of expected {source addr, dest addr, data} writes filled
// before each frame, and a negedge monitor that pops and compares every b1
// write, checks raster read order and read-to-write latency.
module tb_sobel_stream_engine;
    import sobel_pkg::*;

    localparam int DW   = 10;
    localparam int AW   = 16;
    localparam int MW   = 256;
    localparam int EW   = 2 * AW + DW;
    localparam int MAXV = (1 << DW) - 1;

    // ---------------------------------------------------- clock and reset
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic          i_start, i_abort;
    logic [1:0]    i_mode;
    logic [AW-1:0] i_width, i_height;
    logic [DW-1:0] i_thresh;
    logic          b0_ce1;
    logic [AW-1:0] b0_addr1;
    logic [DW-1:0] b0_q1;
    logic          b1_ce1, b1_we1;
    logic [AW-1:0] b1_addr1;
    logic [DW-1:0] b1_d1;
    logic          o_idle, o_busy, o_done, o_err;
    logic [1:0]    o_dbg_state;

    sobel_stream_engine #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .MAX_WIDTH  (MW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_start     (i_start),
        .i_abort     (i_abort),
        .i_mode      (i_mode),
        .i_width     (i_width),
        .i_height    (i_height),
        .i_thresh    (i_thresh),
        .b0_ce1      (b0_ce1),
        .b0_addr1    (b0_addr1),
        .b0_q1       (b0_q1),
        .b1_ce1      (b1_ce1),
        .b1_we1      (b1_we1),
        .b1_addr1    (b1_addr1),
        .b1_d1       (b1_d1),
        .o_idle      (o_idle),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_err       (o_err),
        .o_dbg_state (o_dbg_state)
    );

    // Source BRAM: one-cycle read latency.
    logic [DW-1:0] src_mem [0:65535];
    always @(posedge clk) if (b0_ce1) b0_q1 <= src_mem[b0_addr1];

    // ------------------------------------------------------------ scoreboard
    logic [EW-1:0] exp_q[$];
    logic [31:0]   rd_cyc [0:65535];
    int n_checks = 0, n_pass = 0;
    int cyc = 0, rd_exp = 0, frame_reads = 0, frame_writes = 0;
    int done_cnt = 0, err_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    function automatic void push_exp(int src, int dst, int data);
        exp_q.push_back({AW'(src), AW'(dst), DW'(data)});
    endfunction

    always @(negedge clk) begin : monitor
        logic [EW-1:0] e;
        cyc++;
        if (b0_ce1) begin
            frame_reads++;
            chk("rd_order", b0_addr1, rd_exp);
            rd_exp++;
            rd_cyc[b0_addr1] = cyc;
        end
        if (b1_ce1 !== b1_we1) chk("b1_ce_eq_we", b1_ce1, b1_we1);
        if (b1_we1) begin
            frame_writes++;
            chk("wr_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("wr_addr", b1_addr1, e[DW +: AW]);
                chk("wr_data", b1_d1, e[DW-1:0]);
                chk("wr_latency", cyc - rd_cyc[e[DW+AW +: AW]], 3);
            end
        end
        if (o_done) done_cnt++;
        if (o_err) begin
            err_cnt++;
            chk("err_with_done", o_done, 1);
        end
    end

    // ----------------------------------------------------- reference model
    function automatic int px(int w, int r, int c);
        return int'(src_mem[r * w + c]);
    endfunction

    function automatic int sobel_ref(int w, int r, int c, logic [1:0] mode, int thr);
        int gx, gy, m;
        gx = (px(w, r-1, c+1) + 2 * px(w, r, c+1) + px(w, r+1, c+1))
           - (px(w, r-1, c-1) + 2 * px(w, r, c-1) + px(w, r+1, c-1));
        gy = (px(w, r+1, c-1) + 2 * px(w, r+1, c) + px(w, r+1, c+1))
           - (px(w, r-1, c-1) + 2 * px(w, r-1, c) + px(w, r-1, c+1));
        m = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
        if (m > MAXV) m = MAXV;
        if (mode == MODE_THRESH) m = (m >= thr) ? MAXV : 0;
        return m;
    endfunction

    task automatic push_model(logic [1:0] mode, int w, int h, int thr);
        for (int r = 1; r <= h - 2; r++)
            for (int c = 1; c <= w - 2; c++)
                push_exp((r + 1) * w + c + 1, (r - 1) * (w - 2) + c - 1,
                         sobel_ref(w, r, c, mode, thr));
    endtask

    // Hand-computed 3x3 interior results of a 5x5 frame, raster order.
    task automatic push_table5(input int v [9]);
        for (int i = 0; i < 9; i++)
            push_exp((i / 3 + 2) * 5 + (i % 3) + 2, i, v[i]);
    endtask

    task automatic push_move(int n);
        for (int k = 0; k < n; k++) push_exp(k, k, int'(src_mem[k]));
    endtask

    // --------------------------------------------------------------- stimulus
    task automatic fill_ramp(int n);
        for (int k = 0; k < n; k++) src_mem[k] = DW'(k);
    endtask

    task automatic fill_vstep(int w, int h, int split, int hi);
        for (int r = 0; r < h; r++)
            for (int c = 0; c < w; c++) src_mem[r * w + c] = (c >= split) ? DW'(hi) : '0;
    endtask

    task automatic fill_hstep(int w, int h, int split, int hi);
        for (int r = 0; r < h; r++)
            for (int c = 0; c < w; c++) src_mem[r * w + c] = (r >= split) ? DW'(hi) : '0;
    endtask

    task automatic fill_rand(int w, int h);
        for (int k = 0; k < w * h; k++) src_mem[k] = DW'($urandom_range(0, MAXV));
    endtask

    task automatic start_frame(logic [1:0] mode, int w, int h, int thr);
        frame_reads = 0; frame_writes = 0; done_cnt = 0; err_cnt = 0; rd_exp = 0;
        @(negedge clk);
        i_mode = mode; i_width = AW'(w); i_height = AW'(h); i_thresh = DW'(thr);
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
    endtask

    task automatic run_frame(input string tag, input logic [1:0] mode, input int w,
                             input int h, input int thr, input bit exp_err,
                             input int exp_writes);
        int budget;
        start_frame(mode, w, h, thr);
        chk({tag, ":busy"}, o_busy, !exp_err);
        budget = 0;
        while (done_cnt == 0 && budget < 20000) begin
            @(negedge clk);
            budget++;
        end
        @(negedge clk);
        @(negedge clk);
        chk({tag, ":done_once"}, done_cnt, 1);
        chk({tag, ":err"}, err_cnt, exp_err);
        chk({tag, ":reads"}, frame_reads, exp_err ? 0 : w * h);
        chk({tag, ":writes"}, frame_writes, exp_writes);
        chk({tag, ":queue_empty"}, exp_q.size(), 0);
        chk({tag, ":idle"}, o_idle, 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, ":b0_ce1"}, b0_ce1, 0);
        chk({tag, ":b0_addr1"}, b0_addr1, 0);
        chk({tag, ":b1_we1"}, b1_we1, 0);
        chk({tag, ":b1_ce1"}, b1_ce1, 0);
        chk({tag, ":b1_addr1"}, b1_addr1, 0);
        chk({tag, ":b1_d1"}, b1_d1, 0);
        chk({tag, ":o_idle"}, o_idle, 1);
        chk({tag, ":o_busy"}, o_busy, 0);
        chk({tag, ":o_done"}, o_done, 0);
        chk({tag, ":o_err"}, o_err, 0);
        chk({tag, ":state"}, o_dbg_state, ST_IDLE);
    endtask

    // ------------------------------------------------------------ main flow
    initial begin
        int step_v   [9] = '{400, 400, 0, 400, 400, 0, 400, 400, 0};
        int bin_v    [9] = '{MAXV, MAXV, 0, MAXV, MAXV, 0, MAXV, MAXV, 0};
        int zero_v   [9] = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
        int hstep_v  [9] = '{400, 400, 400, 400, 400, 400, 0, 0, 0};
        int err_m    [5] = '{1, 1, 3, 0, 2};
        int err_w    [5] = '{2, 3, 4, 0, 257};
        int err_h    [5] = '{10, 2, 4, 5, 3};
        int bad;

        rst_n = 1'b0; i_start = 1'b0; i_abort = 1'b0;
        i_mode = '0; i_width = '0; i_height = '0; i_thresh = '0;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // MOVE ramp 4x3 and the smallest legal MOVE frame.
        fill_ramp(12); push_move(12);
        run_frame("move4x3", MODE_MOVE, 4, 3, 0, 0, 12);
        src_mem[0] = DW'(777); push_move(1);
        run_frame("move1x1", MODE_MOVE, 1, 1, 0, 0, 1);

        // Vertical step 0|100 at column 2: centres at columns 1,2 see 400.
        fill_vstep(5, 5, 2, 100); push_table5(step_v);
        run_frame("sobel_vstep", MODE_SOBEL, 5, 5, 0, 0, 9);
        push_table5(bin_v);
        run_frame("thresh128", MODE_THRESH, 5, 5, 128, 0, 9);
        push_table5(bin_v);
        run_frame("thresh_eq", MODE_THRESH, 5, 5, 400, 0, 9);
        push_table5(zero_v);
        run_frame("thresh_above", MODE_THRESH, 5, 5, 401, 0, 9);

        // Full-scale step: 4*MAXV must clamp to MAXV.
        fill_vstep(5, 5, 2, MAXV); push_table5(bin_v);
        run_frame("sobel_sat", MODE_SOBEL, 5, 5, 0, 0, 9);

        // Horizontal step exercises Gy only.
        fill_hstep(5, 5, 2, 100); push_table5(hstep_v);
        run_frame("sobel_hstep", MODE_SOBEL, 5, 5, 0, 0, 9);

        fill_rand(7, 6); push_model(MODE_SOBEL, 7, 6, 0);
        run_frame("sobel_rand", MODE_SOBEL, 7, 6, 0, 0, 20);
        fill_rand(6, 5); push_model(MODE_THRESH, 6, 5, 300);
        run_frame("thresh_rand", MODE_THRESH, 6, 5, 300, 0, 12);

        // Illegal configurations: done+err together, no strobes.
        for (int i = 0; i < 5; i++)
            run_frame($sformatf("cfg_err%0d", i), err_m[i][1:0], err_w[i], err_h[i], 0, 1, 0);

        // Start together with abort in IDLE is ignored.
        frame_reads = 0; done_cnt = 0;
        @(negedge clk);
        i_mode = MODE_MOVE; i_width = 4; i_height = 3; i_start = 1'b1; i_abort = 1'b1;
        @(negedge clk);
        i_start = 1'b0; i_abort = 1'b0;
        repeat (10) @(negedge clk);
        chk("start_abort:reads", frame_reads, 0);
        chk("start_abort:done", done_cnt, 0);
        chk("start_abort:idle", o_idle, 1);

        // Abort a MAX_WIDTH x 4 frame after 300 cycles of READ.
        fill_rand(MW, 4);
        start_frame(MODE_SOBEL, MW, 4, 0);
        repeat (300) @(negedge clk);
        i_abort = 1'b1;
        @(negedge clk);
        i_abort = 1'b0;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (b0_ce1 || b1_we1 || b1_ce1 || o_done || !o_idle) bad++;
            @(negedge clk);
        end
        chk("abort:quiet", bad, 0);
        chk("abort:no_done", done_cnt, 0);
        chk("abort:reads", frame_reads, 301);
        chk("abort:writes", frame_writes, 0);
        fill_vstep(5, 5, 2, 100); push_table5(step_v);
        run_frame("after_abort", MODE_SOBEL, 5, 5, 0, 0, 9);

        // Reset in the middle of a 16x16 frame, then rerun the same frame.
        fill_rand(16, 16); push_model(MODE_SOBEL, 16, 16, 0);
        start_frame(MODE_SOBEL, 16, 16, 0);
        repeat (100) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("mid_reset");
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        push_model(MODE_SOBEL, 16, 16, 0);
        run_frame("rerun16", MODE_SOBEL, 16, 16, 0, 0, 196);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
